// File: rtl/uart_pkg.sv
// Shared constants, FSM encoding and helpers for the parametrised UART receiver.
package uart_pkg;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_PAR       = 3'd3;
  localparam logic [2:0] ST_STOP      = 3'd4;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd5;

  typedef enum logic [2:0] {
    IDLE      = ST_IDLE,
    START     = ST_START,
    DATA      = ST_DATA,
    PAR       = ST_PAR,
    STOP      = ST_STOP,
    WAIT_IDLE = ST_WAIT_IDLE
  } state_t;

  // Counter width that never collapses to zero bits.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/uart_rx_param_if.sv
// Received-word handshake bus: the receiver drives the word and flags, the consumer drives ready.
interface uart_rx_param_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic [DATA_BITS-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_perr;
  logic                 out_ferr;
  logic                 out_brk;

  modport master (output out_data, out_valid, out_perr, out_ferr, out_brk, input out_ready);
  modport slave  (input out_data, out_valid, out_perr, out_ferr, out_brk, output out_ready);
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous RX pin; resets to the idle (high) level.
module uart_rx_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: start-glitch rejection, parity/framing/break checks,
// and a valid/ready holding register with a sticky overrun flag.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 108,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            rx,
  uart_rx_param_if.master word,
  output logic            overrun,
  input  logic            clr_err,
  output logic            busy
);
  localparam int unsigned CW = clog2_min1(CLKS_PER_BIT);
  localparam int unsigned IW = clog2_min1(DATA_BITS + 1);
  localparam int unsigned H  = CLKS_PER_BIT / 2;
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF  = CW'(H - 1);
  localparam logic [IW-1:0] DATA_LAST = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);

  logic                 rx_s;
  state_t               state, state_n;
  logic [CW-1:0]        cnt, cnt_n, cnt_step;
  logic [IW-1:0]        idx, idx_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 par_bit, par_bit_n;
  logic                 perr_r, perr_n;
  logic                 ferr_r, ferr_n;
  logic                 sample;
  logic                 done_c;
  logic                 blocked;

  uart_rx_sync u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (rx),
    .q       (rx_s)
  );

  // Next-state, counters and frame accumulation; done_c marks the last stop sample.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    idx_n     = idx;
    shreg_n   = shreg;
    par_bit_n = par_bit;
    perr_n    = perr_r;
    ferr_n    = ferr_r;
    done_c    = 1'b0;
    sample    = (cnt == CNT_LAST);
    cnt_step  = sample ? '0 : cnt + CW'(1);

    unique case (state)
      IDLE: begin
        cnt_n     = '0;
        idx_n     = '0;
        par_bit_n = 1'b0;
        perr_n    = 1'b0;
        ferr_n    = 1'b0;
        if (!rx_s) state_n = START;
      end
      START: begin
        if (cnt == CNT_HALF) begin
          cnt_n   = '0;
          state_n = rx_s ? IDLE : DATA;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      DATA: begin
        cnt_n = cnt_step;
        if (sample) begin
          shreg_n = {rx_s, shreg[DATA_BITS-1:1]};
          if (idx == DATA_LAST) begin
            idx_n   = '0;
            state_n = (PARITY != PAR_NONE) ? PAR : STOP;
          end else begin
            idx_n = idx + IW'(1);
          end
        end
      end
      PAR: begin
        cnt_n = cnt_step;
        if (sample) begin
          par_bit_n = rx_s;
          perr_n    = (^shreg) ^ rx_s ^ (PARITY == PAR_ODD);
          state_n   = STOP;
        end
      end
      STOP: begin
        cnt_n = cnt_step;
        if (sample) begin
          if (!rx_s) ferr_n = 1'b1;
          if (idx == STOP_LAST) begin
            done_c  = 1'b1;
            idx_n   = '0;
            state_n = ferr_n ? WAIT_IDLE : IDLE;
          end else begin
            idx_n = idx + IW'(1);
          end
        end
      end
      WAIT_IDLE: begin
        cnt_n = '0;
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
      perr_r  <= 1'b0;
      ferr_r  <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      idx     <= idx_n;
      shreg   <= shreg_n;
      par_bit <= par_bit_n;
      perr_r  <= perr_n;
      ferr_r  <= ferr_n;
      busy    <= (state_n != IDLE);
    end
  end

  // A completed frame is dropped only if the held word is not leaving this cycle.
  assign blocked = done_c && word.out_valid && !word.out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word.out_data  <= '0;
      word.out_valid <= 1'b0;
      word.out_perr  <= 1'b0;
      word.out_ferr  <= 1'b0;
      word.out_brk   <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      if (done_c && !blocked) begin
        word.out_data  <= shreg;
        word.out_valid <= 1'b1;
        word.out_perr  <= perr_r;
        word.out_ferr  <= ferr_n;
        word.out_brk   <= ferr_n && (shreg == '0) && !par_bit;
      end else if (word.out_valid && word.out_ready) begin
        word.out_valid <= 1'b0;
      end
      if (clr_err) overrun <= 1'b0;
      if (blocked) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: frame-level model of word delivery plus directed literal checks.
module tb_uart_rx_param;
  localparam int unsigned C      = 16;
  localparam int unsigned H      = C / 2;
  localparam int unsigned DONE_N = 3 + H + 9 * C;   // 8N1: last stop is frame bit 9
  localparam int unsigned DONE_E = 3 + H + 10 * C;  // 8E1: last stop is frame bit 10

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic rx_n = 1'b1, rx_e = 1'b1;
  logic clr_n = 1'b0, clr_e = 1'b0;
  logic overrun_n, overrun_e, busy_n, busy_e;

  always #5 clk = ~clk;

  uart_rx_param_if #(.DATA_BITS(8)) bus_n ();
  uart_rx_param_if #(.DATA_BITS(8)) bus_e ();

  uart_rx_param #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_n (
    .clk(clk), .reset_n(reset_n), .rx(rx_n), .word(bus_n),
    .overrun(overrun_n), .clr_err(clr_n), .busy(busy_n));

  uart_rx_param #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dut_e (
    .clk(clk), .reset_n(reset_n), .rx(rx_e), .word(bus_e),
    .overrun(overrun_e), .clr_err(clr_e), .busy(busy_e));

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  int unsigned edge_n = 0;
  int unsigned last_n0 = 0;

  typedef struct {
    int unsigned at;
    logic [7:0]  data;
    logic        ferr;
    logic        brk;
  } ev_t;
  ev_t pend[$];

  logic       m_valid, m_ferr, m_brk, m_ov;
  logic [7:0] m_data;
  logic       done, blocked;

  bit          c_ok;
  int unsigned c_lat;
  logic [7:0]  c_data;
  logic        c_perr, c_ferr, c_brk, c_next;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected word for an 8N1 frame whose start edge was driven just after edge last_n0.
  function automatic void schedule(input logic [7:0] d, input logic stop);
    ev_t e;
    e.at   = last_n0 + DONE_N;
    e.data = d;
    e.ferr = !stop;
    e.brk  = !stop && (d == 8'h00);
    pend.push_back(e);
  endfunction

  // Model of the holding register driven by the scheduled frame completions.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_valid = 1'b0; m_data = 8'h00; m_ferr = 1'b0; m_brk = 1'b0; m_ov = 1'b0;
      pend.delete();
    end else begin
      edge_n++;
      done    = (pend.size() != 0) && (pend[0].at == edge_n);
      blocked = done && m_valid && !bus_n.out_ready;
      if (done) begin
        if (!blocked) begin
          m_valid = 1'b1;
          m_data  = pend[0].data;
          m_ferr  = pend[0].ferr;
          m_brk   = pend[0].brk;
        end
        pend.delete(0);
      end else if (m_valid && bus_n.out_ready) begin
        m_valid = 1'b0;
      end
      if (clr_n) m_ov = 1'b0;
      if (blocked) m_ov = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (!reset_n) begin
      check("rst_valid",   32'(bus_n.out_valid), 32'd0);
      check("rst_data",    32'(bus_n.out_data),  32'd0);
      check("rst_overrun", 32'(overrun_n),       32'd0);
      check("rst_busy",    32'(busy_n),          32'd0);
    end else begin
      check("valid", 32'(bus_n.out_valid), 32'(m_valid));
      if (m_valid) begin
        check("data", 32'(bus_n.out_data), 32'(m_data));
        check("perr", 32'(bus_n.out_perr), 32'd0);
        check("ferr", 32'(bus_n.out_ferr), 32'(m_ferr));
        check("brk",  32'(bus_n.out_brk),  32'(m_brk));
      end
      check("overrun", 32'(overrun_n), 32'(m_ov));
    end
  end

  task automatic hold(input int line, input logic v, input int unsigned n);
    if (line == 0) rx_n = v; else rx_e = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_n(input logic [7:0] d, input logic stop);
    @(posedge clk); #1;
    last_n0 = edge_n;
    schedule(d, stop);
    hold(0, 1'b0, C);
    for (int i = 0; i < 8; i++) hold(0, d[i], C);
    hold(0, stop, C);
  endtask

  task automatic send_e(input logic [7:0] d, input logic pbit);
    @(posedge clk); #1;
    last_n0 = edge_n;
    hold(1, 1'b0, C);
    for (int i = 0; i < 8; i++) hold(1, d[i], C);
    hold(1, pbit, C);
    hold(1, 1'b1, C);
  endtask

  // Capture the first valid word on a line plus the valid level one cycle later.
  task automatic catch_word(input int line);
    c_ok = 1'b0;
    for (int i = 0; i < 400 && !c_ok; i++) begin
      @(negedge clk);
      c_ok = (line == 0) ? bus_n.out_valid : bus_e.out_valid;
    end
    c_lat  = edge_n - last_n0;
    c_data = (line == 0) ? bus_n.out_data : bus_e.out_data;
    c_perr = (line == 0) ? bus_n.out_perr : bus_e.out_perr;
    c_ferr = (line == 0) ? bus_n.out_ferr : bus_e.out_ferr;
    c_brk  = (line == 0) ? bus_n.out_brk  : bus_e.out_brk;
    @(negedge clk);
    c_next = (line == 0) ? bus_n.out_valid : bus_e.out_valid;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus_n.out_ready = 1'b1;
    bus_e.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_valid", 32'(bus_n.out_valid), 32'd0);
    check("reset_busy",  32'(busy_n),          32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    hold(0, 1'b1, 4);

    // 1: 8N1 0xA5, one-cycle pulse, timing from the start edge
    fork
      send_n(8'hA5, 1'b1);
      catch_word(0);
    join
    check("t1_seen",    32'(c_ok),   32'd1);
    check("t1_latency", c_lat,       32'd155);
    check("t1_data",    32'(c_data), 32'hA5);
    check("t1_flags",   32'({c_perr, c_ferr, c_brk}), 32'd0);
    check("t1_pulse",   32'(c_next), 32'd0);

    // 2: even parity, wrong then right parity bit for 0x3C
    fork
      send_e(8'h3C, 1'b1);
      catch_word(1);
    join
    check("t2_seen",    32'(c_ok),   32'd1);
    check("t2_latency", c_lat,       32'd171);
    check("t2_data",    32'(c_data), 32'h3C);
    check("t2_perr1",   32'(c_perr), 32'd1);
    check("t2_ferr1",   32'(c_ferr), 32'd0);
    fork
      send_e(8'h3C, 1'b0);
      catch_word(1);
    join
    check("t2_data0",   32'(c_data), 32'h3C);
    check("t2_perr0",   32'(c_perr), 32'd0);

    // 3: 5-cycle glitch rejected, then 0x55
    hold(0, 1'b0, 5);
    check("t3_busy_hi", 32'(busy_n), 32'd1);
    hold(0, 1'b1, 30);
    check("t3_busy_lo", 32'(busy_n), 32'd0);
    fork
      send_n(8'h55, 1'b1);
      catch_word(0);
    join
    check("t3_data", 32'(c_data), 32'h55);
    check("t3_ferr", 32'(c_ferr), 32'd0);

    // 4: break held three frame times, then 0x81
    @(posedge clk); #1;
    last_n0 = edge_n;
    schedule(8'h00, 1'b0);
    fork
      hold(0, 1'b0, 480);
      catch_word(0);
    join
    check("t4_data", 32'(c_data), 32'h00);
    check("t4_ferr", 32'(c_ferr), 32'd1);
    check("t4_brk",  32'(c_brk),  32'd1);
    check("t4_busy_wait", 32'(busy_n), 32'd1);
    hold(0, 1'b1, 20);
    check("t4_busy_idle", 32'(busy_n), 32'd0);
    fork
      send_n(8'h81, 1'b1);
      catch_word(0);
    join
    check("t4_next_data", 32'(c_data), 32'h81);
    check("t4_next_err",  32'({c_ferr, c_brk}), 32'd0);

    // 5: overrun, clear, and the simultaneous accept/complete case
    bus_n.out_ready = 1'b0;
    send_n(8'h11, 1'b1);
    send_n(8'h22, 1'b1);
    hold(0, 1'b1, 10);
    check("t5_held_data", 32'(bus_n.out_data),  32'h11);
    check("t5_held_vld",  32'(bus_n.out_valid), 32'd1);
    check("t5_overrun",   32'(overrun_n),       32'd1);
    bus_n.out_ready = 1'b1;
    @(posedge clk); #1;
    bus_n.out_ready = 1'b0;
    check("t5_accept",    32'(bus_n.out_valid), 32'd0);
    check("t5_ovr_kept",  32'(overrun_n),       32'd1);
    clr_n = 1'b1;
    @(posedge clk); #1;
    clr_n = 1'b0;
    check("t5_clr", 32'(overrun_n), 32'd0);
    send_n(8'h44, 1'b1);
    hold(0, 1'b1, 5);
    fork
      send_n(8'h33, 1'b1);
      begin
        @(posedge clk); #1;
        repeat (DONE_N - 1) @(posedge clk);
        #1;
        bus_n.out_ready = 1'b1;
        @(posedge clk); #1;
        bus_n.out_ready = 1'b0;
      end
    join
    hold(0, 1'b1, 5);
    check("t5_swap_vld",  32'(bus_n.out_valid), 32'd1);
    check("t5_swap_data", 32'(bus_n.out_data),  32'h33);
    check("t5_swap_ovr",  32'(overrun_n),       32'd0);

    // 6: reset in the middle of 0xF0, then 0x0F
    @(posedge clk); #1;
    last_n0 = edge_n;
    schedule(8'hF0, 1'b1);
    hold(0, 1'b0, C);
    hold(0, 1'b0, 3 * C + 5);
    reset_n = 1'b0;
    rx_n = 1'b1;
    #1;
    check("t6_rst_valid", 32'(bus_n.out_valid), 32'd0);
    check("t6_rst_data",  32'(bus_n.out_data),  32'd0);
    check("t6_rst_busy",  32'(busy_n),          32'd0);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    bus_n.out_ready = 1'b1;
    hold(0, 1'b1, 5);
    fork
      send_n(8'h0F, 1'b1);
      catch_word(0);
    join
    check("t6_seen",  32'(c_ok),   32'd1);
    check("t6_data",  32'(c_data), 32'h0F);
    check("t6_flags", 32'({c_perr, c_ferr, c_brk}), 32'd0);
    check("t6_pulse", 32'(c_next), 32'd0);

    hold(0, 1'b1, 30);
    check("pending_drained", 32'(pend.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
